// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: front-panel nibble entry of NUM_OPS operands, ALU
// launch with start/done handshake and timeout, and a paged hex display.
// In : clk, rst_n, key_enter_n/key_run_n/key_page_n (raw, active low),
//      sel_i, digit_i, oper_i, alu_done_i, result_i
// Out: operands_o, oper_o, start_o, busy_o, result_o, result_valid_o,
//      err_o, nib_ptr_o, disp_o
module operand_entry_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2,
  parameter int OPER_W  = 3,
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 255,
  localparam int NIBS   = WIDTH / 4,
  localparam int NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_enter_n,
  input  logic                     key_run_n,
  input  logic                     key_page_n,
  input  logic [1:0]               sel_i,
  input  logic [3:0]               digit_i,
  input  logic [OPER_W-1:0]        oper_i,
  input  logic                     alu_done_i,
  input  logic [WIDTH-1:0]         result_i,
  output logic [NUM_OPS*WIDTH-1:0] operands_o,
  output logic [OPER_W-1:0]        oper_o,
  output logic                     start_o,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         result_o,
  output logic                     result_valid_o,
  output logic                     err_o,
  output logic [NIB_W-1:0]         nib_ptr_o,
  output logic [4*DIGITS-1:0]      disp_o
);

  localparam int PW     = 4 * DIGITS;
  localparam int PAGES  = WIDTH / PW;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Bit order in key vectors: [0] enter, [1] run, [2] page.
  logic [2:0] ks1, ks2, kprev, press;
  logic       enter_p, run_p, page_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks1   <= '1;
      ks2   <= '1;
      kprev <= '1;
    end else begin
      ks1   <= {key_page_n, key_run_n, key_enter_n};
      ks2   <= ks1;
      kprev <= ks2;
    end
  end

  // Falling edge of the synchronised key: one pulse per press.
  assign press   = ~ks2 & kprev;
  assign enter_p = press[0];
  assign run_p   = press[1];
  assign page_p  = press[2];

  logic [1:0]        sel_q;
  logic [PAGE_W-1:0] page_q;
  logic [WIDTH-1:0]  stg_q [NUM_OPS];
  logic [WIDTH-1:0]  stg_n [NUM_OPS];
  logic              sel_hit, wr_en;

  assign sel_hit = (sel_i == sel_q);
  assign wr_en   = enter_p & sel_hit & (int'(sel_q) < NUM_OPS);

  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) begin
      stg_n[i] = stg_q[i];
      for (int n = 0; n < NIBS; n++) begin
        if (wr_en && int'(sel_q) == i && int'(nib_ptr_o) == n)
          stg_n[i][n*4 +: 4] = digit_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      page_q    <= '0;
      nib_ptr_o <= '0;
      for (int i = 0; i < NUM_OPS; i++)
        stg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++)
        stg_q[i] <= stg_n[i];
      // First Enter on a new selection only selects.
      if (enter_p && !sel_hit) begin
        sel_q     <= sel_i;
        nib_ptr_o <= '0;
        page_q    <= '0;
      end else begin
        if (wr_en)
          nib_ptr_o <= (int'(nib_ptr_o) == NIBS - 1) ?
                       '0 : nib_ptr_o + 1'b1;
        if (page_p)
          page_q <= (int'(page_q) == PAGES - 1) ?
                    '0 : page_q + 1'b1;
      end
    end
  end

  logic [WIDTH-1:0]         src;
  logic [PW-1:0]            disp_n;
  logic [NUM_OPS*WIDTH-1:0] stg_flat;

  always_comb begin
    src = '0;
    for (int i = 0; i < NUM_OPS; i++)
      if (int'(sel_i) == i) src = stg_q[i];
    if (int'(sel_i) == NUM_OPS) src = result_o;
    disp_n = '0;
    for (int p = 0; p < PAGES; p++)
      if (int'(page_q) == p) disp_n = src[p*PW +: PW];
  end

  always_comb begin
    stg_flat = '0;
    for (int i = 0; i < NUM_OPS; i++)
      stg_flat[i*WIDTH +: WIDTH] = stg_q[i];
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      operands_o     <= '0;
      oper_o         <= '0;
      start_o        <= 1'b0;
      busy_o         <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      err_o          <= 1'b0;
      disp_o         <= '0;
    end else begin
      disp_o <= disp_n;
      case (state_q)
        S_IDLE: begin
          if (run_p) begin
            operands_o     <= stg_flat;
            oper_o         <= oper_i;
            start_o        <= 1'b1;
            busy_o         <= 1'b1;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
            cnt_q          <= '0;
            state_q        <= S_WAIT;
          end
        end
        S_WAIT: begin
          start_o <= 1'b0;
          // Done alongside start_o belongs to no launch of ours.
          if (alu_done_i && !start_o) begin
            result_o       <= result_i;
            result_valid_o <= 1'b1;
            busy_o         <= 1'b0;
            state_q        <= S_IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
